// File: rtl/ball_motion_ctrl_if.sv
// Draw handshake between the ball motion sequencer and the VGA plotting stage.
// The sequencer is the master: it raises draw_req and the plotter answers with draw_ack.
interface ball_motion_ctrl_if;
  logic draw_req;
  logic draw_erase;
  logic draw_ack;

  modport master (output draw_req, output draw_erase, input draw_ack);
  modport slave  (input draw_req, input draw_erase, output draw_ack);
endinterface

// File: rtl/ball_motion_ctrl.sv
// Per-frame ball motion sequencer: erase, sample collision, reflect, step, redraw.
// Optional build macro BALL_SPEEDUP_EN adds step speed-up on every SPEEDUP_EVERY Y reflections.
//
// state  | meaning
// IDLE   | waiting for frame_tick or a pending tick
// ERASE  | background-colour plot request at the current position
// SAMPLE | position stable, down-counting to the collision latch
// TURN   | reflect dir from the latched collision code
// MOVE   | step position with clamping at the field edges
// DRAW   | ball-colour plot request at the new position
module ball_motion_ctrl #(
  parameter logic [9:0] X_INIT        = 10'd320,
  parameter logic [9:0] Y_INIT        = 10'd240,
  parameter logic [1:0] DIR_INIT      = 2'b00,
  parameter logic [6:0] STEP_INIT     = 7'd1,
  parameter logic [9:0] X_MAX         = 10'd639,
  parameter logic [9:0] Y_MAX         = 10'd479,
  parameter int         SAMPLE_WAIT   = 2,
  parameter int         SPEEDUP_EVERY = 4,
  parameter logic [6:0] STEP_MAX      = 7'd8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                frame_tick,
  input  logic [1:0]          collision,
  ball_motion_ctrl_if.master  draw,
  output logic [9:0]          ball_x,
  output logic [9:0]          ball_y,
  output logic [6:0]          xstep,
  output logic [6:0]          ystep,
  output logic [1:0]          dir,
  output logic                busy,
  output logic                overrun
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ERASE  = 3'd1;
  localparam logic [2:0] S_SAMPLE = 3'd2;
  localparam logic [2:0] S_TURN   = 3'd3;
  localparam logic [2:0] S_MOVE   = 3'd4;
  localparam logic [2:0] S_DRAW   = 3'd5;

  localparam int CW = $clog2(SAMPLE_WAIT + 1);

  if (SAMPLE_WAIT < 1 || SPEEDUP_EVERY < 1 || STEP_MAX < STEP_INIT) begin : g_bad_cfg
    $error("ball_motion_ctrl: invalid parameter set");
  end

  logic [2:0]    state;
  logic          pending;
  logic [1:0]    coll_q;
  logic [CW-1:0] wait_cnt;
  logic [10:0]   x_sum, y_sum;
  logic [9:0]    x_next, y_next;

`ifdef BALL_SPEEDUP_EN
  localparam int RW = $clog2(SPEEDUP_EVERY + 1);
  logic [RW-1:0] refl_cnt;
`endif

  // 11-bit sums so the upper clamp never sees a wrapped value
  always_comb begin
    x_sum = {1'b0, ball_x} + {4'b0, xstep};
    y_sum = {1'b0, ball_y} + {4'b0, ystep};
    if (dir[0]) x_next = (ball_x < {3'b0, xstep}) ? 10'd0 : ball_x - {3'b0, xstep};
    else        x_next = (x_sum > {1'b0, X_MAX}) ? X_MAX : x_sum[9:0];
    if (dir[1]) y_next = (ball_y < {3'b0, ystep}) ? 10'd0 : ball_y - {3'b0, ystep};
    else        y_next = (y_sum > {1'b0, Y_MAX}) ? Y_MAX : y_sum[9:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= S_IDLE;
      pending         <= 1'b0;
      overrun         <= 1'b0;
      busy            <= 1'b0;
      coll_q          <= 2'b00;
      wait_cnt        <= '0;
      ball_x          <= X_INIT;
      ball_y          <= Y_INIT;
      dir             <= DIR_INIT;
      xstep           <= STEP_INIT;
      ystep           <= STEP_INIT;
      draw.draw_req   <= 1'b0;
      draw.draw_erase <= 1'b0;
`ifdef BALL_SPEEDUP_EN
      refl_cnt        <= '0;
`endif
    end else begin
      // one-deep tick queue; a tick on the DRAW->IDLE edge lands here too
      if (busy && frame_tick) begin
        if (pending) overrun <= 1'b1;
        else         pending <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (frame_tick || pending) begin
            state           <= S_ERASE;
            pending         <= 1'b0;
            busy            <= 1'b1;
            draw.draw_req   <= 1'b1;
            draw.draw_erase <= 1'b1;
          end
        end
        S_ERASE: begin
          if (draw.draw_ack) begin
            state           <= S_SAMPLE;
            wait_cnt        <= CW'(SAMPLE_WAIT);
            draw.draw_req   <= 1'b0;
            draw.draw_erase <= 1'b0;
          end
        end
        S_SAMPLE: begin
          if (wait_cnt == '0) begin
            coll_q <= collision;
            state  <= S_TURN;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_TURN: begin
          if (coll_q == 2'b10) dir[0] <= ~dir[0];
          if (coll_q == 2'b11) dir[1] <= ~dir[1];
`ifdef BALL_SPEEDUP_EN
          if (coll_q == 2'b11) begin
            if (refl_cnt == RW'(SPEEDUP_EVERY - 1)) begin
              refl_cnt <= '0;
              if (xstep < STEP_MAX) xstep <= xstep + 7'd1;
              if (ystep < STEP_MAX) ystep <= ystep + 7'd1;
            end else begin
              refl_cnt <= refl_cnt + 1'b1;
            end
          end
`endif
          state <= S_MOVE;
        end
        S_MOVE: begin
          ball_x          <= x_next;
          ball_y          <= y_next;
          state           <= S_DRAW;
          draw.draw_req   <= 1'b1;
          draw.draw_erase <= 1'b0;
        end
        S_DRAW: begin
          if (draw.draw_ack) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            draw.draw_req <= 1'b0;
          end
        end
        default: begin
          state           <= S_IDLE;
          busy            <= 1'b0;
          draw.draw_req   <= 1'b0;
          draw.draw_erase <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ball_motion_ctrl.md
# ball_motion_ctrl

Per-frame ball motion sequencer for the breakout datapath. On each frame tick it erases the ball, samples the registered collision code from the edge/collision checker, reflects the direction, steps the position, and redraws the ball through a req/ack handshake with the VGA plotting stage. It sits directly upstream of the checkers, driving their position/step inputs, and downstream of them, consuming their collision code.

## Interface
- `X_INIT`, 10'd320: reset X position
- `Y_INIT`, 10'd240: reset Y position
- `DIR_INIT`, 2'b00: reset direction
- `STEP_INIT`, 7'd1: reset X and Y step
- `X_MAX`, 10'd639: largest legal X
- `Y_MAX`, 10'd479: largest legal Y
- `SAMPLE_WAIT`, 2: cycles between position stable and collision sampled (≥1)
- `SPEEDUP_EVERY`, 4: Y reflections per step increment (speed-up build only)
- `STEP_MAX`, 7'd8: step ceiling (speed-up build only)

- `clk` in 1: system clock, rising edge
- `resetn` in 1: asynchronous active-low reset
- `frame_tick` in 1: one-cycle pulse requesting one motion update
- `collision` in 2: registered checker code; 2'b10 X hit, 2'b11 Y hit, 2'b0x none
- `draw_ack` in 1: plotter accepted the current draw request
- `ball_x` out 10: current X, to checker and plotter
- `ball_y` out 10: current Y
- `xstep` out 7: current X step, to checker
- `ystep` out 7: current Y step
- `dir` out 2: bit0 X sense (0 = +X, 1 = −X); bit1 Y sense (0 = +Y, 1 = −Y)
- `draw_req` out 1: plot request, position on `ball_x`/`ball_y`
- `draw_erase` out 1: qualifies `draw_req`; 1 = background colour, 0 = ball colour
- `busy` out 1: high whenever state ≠ IDLE
- `overrun` out 1: sticky; set when a tick arrives while one is already pending

## Operation
- States: IDLE, ERASE, SAMPLE, TURN, MOVE, DRAW.
- IDLE: on `frame_tick` or a pending tick, go to ERASE and clear pending.
- ERASE: `draw_req`=1, `draw_erase`=1. Leave for SAMPLE in the cycle `draw_ack` is sampled high.
- SAMPLE: count `SAMPLE_WAIT` cycles. Latch `collision` on the last count, then go to TURN.
- TURN: one cycle. Code 2'b10 toggles `dir[0]`, code 2'b11 toggles `dir[1]`, otherwise `dir` is unchanged. Go to MOVE.
- MOVE: one cycle, using the updated `dir`.
  - X: if `dir[0]`=0, `ball_x` = min(`ball_x`+`xstep`, `X_MAX`); else `ball_x` = (`ball_x` < `xstep`) ? 0 : `ball_x`−`xstep`.
  - Y: same rule using `dir[1]`, `ystep`, and `Y_MAX`.
  - Sums are computed at 11 bits before clamping, so there is no wrap-around.
- DRAW: `draw_req`=1, `draw_erase`=0. Leave for IDLE on `draw_ack`.
- Pending tick: a `frame_tick` while `busy`=1 sets a one-deep pending flag. A further tick while pending is already set drops that tick and sets `overrun`. `overrun` clears only on reset.
- A tick in the same cycle as DRAW→IDLE sets pending, so it is served from IDLE on the next cycle.
- `draw_ack` outside ERASE/DRAW is ignored.
- `xstep` and `ystep` are constant at `STEP_INIT` unless the speed-up build is selected.

## Timing
- Reset values:
  - `ball_x`=`X_INIT`, `ball_y`=`Y_INIT`, `dir`=`DIR_INIT`, steps=`STEP_INIT`.
  - `draw_req`, `draw_erase`, `busy`, `overrun`, and pending = 0; state IDLE.
  - Reset mid-operation drops `draw_req` immediately and abandons the update.
- Tick sampled in IDLE at edge N: `draw_req`=1 from N+1.
- `draw_req` holds until the edge that samples `draw_ack`=1, and is low the following cycle.
- Zero-wait ack, tick to IDLE is 5 + `SAMPLE_WAIT` cycles.
- `ball_x`/`ball_y` are stable from ERASE entry through the SAMPLE latch, and change only at the MOVE edge.
- All outputs are registered.

## Configuration
- `BALL_SPEEDUP_EN` defined:
  - A reflection counter increments on each TURN with code 2'b11.
  - On reaching `SPEEDUP_EVERY`, the counter clears and both steps increment, saturating at `STEP_MAX`.
  - The new step takes effect in the same update's MOVE.
- `BALL_SPEEDUP_EN` undefined: no counter; steps are fixed at `STEP_INIT`.

## Test plan
- **No collision:** reset, `collision`=00, ack tied high, one tick → `ball_x`=321, `ball_y`=241, `dir`=00, `busy` high exactly 7 cycles.
- **X reflection:** `ball_x`=639, `collision`=10 held through SAMPLE → `dir`=01, `ball_x`=638, `ball_y`=241.
- **Low-end clamp:** `dir`=11, `ball_x`=0, `ball_y`=0, `collision`=00, step 1 → both positions stay 0; the update completes normally.
- **Handshake hold:** `draw_ack` low for 5 cycles in ERASE → `draw_req`/`draw_erase` high for 6 cycles, no state advance, position unchanged.
- **Pending and overrun:** three ticks during one busy update → one extra update runs back-to-back, `overrun`=1; then reset mid-DRAW → `draw_req`=0, `overrun`=0, position at INIT.
- **Speed-up (`BALL_SPEEDUP_EN`):** 4 updates each with `collision`=11 → `xstep`=`ystep`=2 after the 4th; 32 such updates → steps saturate at 8.
